// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
// Groups the E-stage request and HI/LO result signals of the multiply/divide
// unit into one bundle.
//   start  - launch multu/divu/mult/div this cycle
//   MD_op  - 0 none, 1 multu, 2 divu, 3 mult, 4 div, 5 mthi, 6 mtlo, 7 none
//   A, B   - rs / rt operands
//   cancel - flush of the E-stage instruction (no launch, no HI/LO write)
//   busy   - operation in flight (registered)
//   HI, LO - architectural HI/LO registers (registered)
// master: pipeline side that issues requests.
// slave : the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  MD_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MD_op, A, B, cancel,
    input  busy, HI, LO
  );

  modport slave (
    input  start, MD_op, A, B, cancel,
    output busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Fixed-latency multiply/divide unit with architectural HI/LO registers.
// The result is computed when the operation launches and held until the
// latency counter expires, so HI/LO change exactly MULT_CYC / DIV_CYC cycles
// after launch, at the same edge busy falls.
// Ports:
//   clk    - sole clock, rising edge
//   reset  - synchronous active-high reset
//   bus    - mult_div_unit_if.slave (start, MD_op, A, B, cancel -> busy, HI, LO)
// Parameters:
//   MULT_CYC - multiply latency in cycles (1..16)
//   DIV_CYC  - divide latency in cycles (1..16)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no operation in flight; accepts launch, mthi, mtlo
// RUN   | counting down; pending result written to HI/LO when cnt reaches 0
module mult_div_unit #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] res_hi_q;
  logic [31:0] res_lo_q;
  logic        nowrite_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // ---------------------------------------------------------------------
  // Result datapath, evaluated from the operands presented at launch.
  // ---------------------------------------------------------------------
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] divisor_safe;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic        is_mult;
  logic        is_launch_op;
  logic        div_by_zero;
  logic [31:0] res_hi_d;
  logic [31:0] res_lo_d;
  logic [3:0]  cnt_load_d;

  always_comb begin
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});

    // A zero divisor never produces a result (nowrite), so substitute 1 to
    // keep the divider free of undefined behaviour.
    divisor_safe = (bus.B == 32'd0) ? 32'd1 : bus.B;
    quot_u       = bus.A / divisor_safe;
    rem_u        = bus.A % divisor_safe;

    // Signed divide on magnitudes: quotient sign is sign(A)^sign(B),
    // remainder follows A. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    abs_a  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
    abs_b  = divisor_safe[31] ? (~divisor_safe + 32'd1) : divisor_safe;
    q_mag  = abs_a / abs_b;
    r_mag  = abs_a % abs_b;
    quot_s = (bus.A[31] ^ divisor_safe[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s  = bus.A[31] ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    res_hi_d     = 32'd0;
    res_lo_d     = 32'd0;
    is_mult      = 1'b0;
    is_launch_op = 1'b0;
    div_by_zero  = 1'b0;
    unique case (bus.MD_op)
      OP_MULTU: begin
        {res_hi_d, res_lo_d} = prod_u;
        is_mult      = 1'b1;
        is_launch_op = 1'b1;
      end
      OP_MULT: begin
        {res_hi_d, res_lo_d} = prod_s;
        is_mult      = 1'b1;
        is_launch_op = 1'b1;
      end
      OP_DIVU: begin
        res_hi_d     = rem_u;
        res_lo_d     = quot_u;
        is_launch_op = 1'b1;
        div_by_zero  = (bus.B == 32'd0);
      end
      OP_DIV: begin
        res_hi_d     = rem_s;
        res_lo_d     = quot_s;
        is_launch_op = 1'b1;
        div_by_zero  = (bus.B == 32'd0);
      end
      default: ;
    endcase
    cnt_load_d = is_mult ? MULT_LOAD : DIV_LOAD;
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered busy/HI/LO.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      res_hi_q  <= 32'd0;
      res_lo_q  <= 32'd0;
      nowrite_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.cancel) begin
            if (bus.start && is_launch_op) begin
              res_hi_q  <= res_hi_d;
              res_lo_q  <= res_lo_d;
              nowrite_q <= div_by_zero;
              cnt_q     <= cnt_load_d;
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end else if (bus.MD_op == OP_MTHI) begin
              hi_q <= bus.A;
            end else if (bus.MD_op == OP_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end
        RUN: begin
          // Requests and cancel are ignored here; the pipeline stalls on busy.
          if (cnt_q == 4'd0) begin
            if (!nowrite_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            nowrite_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: MULT_CYC, default 5, multiply latency in cycles; DIV_CYC, default 10, divide latency in cycles.
REQ-002 Single clock, synchronous active-high reset; ports listed below, clock and reset first.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  launch mult/multu/div/divu this cycle; asserted only with MD_op 1..4.
REQ-006 MD_op  input  3  0 none, 1 multu, 2 divu, 3 mult, 4 div, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-008 B  input  32  rt operand (divisor / multiplier).
REQ-009 cancel  input  1  exception/interrupt flush of the E-stage instruction; suppresses any launch or HI/LO write this cycle.
REQ-010 busy  output  1  operation in flight; registered.
REQ-011 HI  output  32  HI register, registered.
REQ-012 LO  output  32  LO register, registered.

Function
REQ-013 States: IDLE, RUN; 4-bit down-counter cnt; latched pending result res_hi/res_lo and flag nowrite.
REQ-014 IDLE, start=1, cancel=0, MD_op in 1..4 at edge T: compute result from A,B, latch it, cnt<=N-1 (N=MULT_CYC for 1/3, DIV_CYC for 2/4), busy<=1, go RUN.
REQ-015 RUN: each edge cnt decrements; at edge where cnt==0: HI<=res_hi, LO<=res_lo (unless nowrite), busy<=0, go IDLE.
REQ-016 Latency: busy high exactly N cycles after launch edge; HI/LO new value visible same cycle busy first reads 0.
REQ-017 multu: {HI,LO} = zero-extended A * zero-extended B, 64-bit.
REQ-018 mult: {HI,LO} = sign-extended A * sign-extended B, 64-bit two's complement.
REQ-019 divu: LO = A/B unsigned, HI = A%B unsigned.
REQ-020 div: LO = quotient truncated toward zero, HI = remainder with sign of A; 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-021 Divide by zero (B==0, op 2/4): full DIV_CYC busy period runs; nowrite=1; HI/LO unchanged at completion.
REQ-022 mthi (5) / mtlo (6) in IDLE, cancel=0: HI<=A / LO<=A at that edge; busy stays 0; start ignored.
REQ-023 In RUN: start, mthi, mtlo ignored; latched result unaffected (pipeline stalls on start|busy).
REQ-024 cancel=1: no launch, no HI/LO write that cycle; cancel does not abort an operation already in RUN.
REQ-025 start=1 with MD_op 0/5/6/7: no launch; MD_op 5/6 still perform write per REQ-022.
REQ-026 Completion edge with new start same edge is impossible (still RUN); new launch accepted earliest the following IDLE cycle.

Reset
REQ-027 reset=1 at an edge: busy=0, HI=0, LO=0, cnt=0, nowrite=0, state IDLE; in-flight result discarded; reset dominates all inputs.
REQ-028 Reset mid-RUN: no HI/LO write ever occurs for the aborted operation.

Verification
REQ-029 mult A=0xFFFFFFFF, B=0x00000002 -> busy 1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7,B=2 -> LO=3, HI=1.
REQ-031 HI=0x11, LO=0x22 preloaded via mthi/mtlo; divu B=0 -> busy 10 cycles; HI=0x11, LO=0x22 afterwards.
REQ-032 During mult RUN apply start+divu and mtlo A=0x55 -> ignored; final HI/LO equal mult result; busy still drops after exactly 5 cycles.
REQ-033 start+mult with cancel=1 -> busy stays 0, HI/LO unchanged; mthi A=0x99 with cancel=1 -> HI unchanged.
REQ-034 reset asserted on 3rd busy cycle of div -> next cycle busy=0, HI=LO=0; no later write.
